// File: rtl/div_tick_scheduler_pkg.sv
// ============================================================================
// Module      : sched_pkg
// Description : Shared types and constants for the tick scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package sched_pkg;

    localparam int DIV_W = 8;
    localparam int STAT_W = 16;
    localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // A divide ratio of 0 behaves like 1: tick every cycle.
    function automatic logic [DIV_W-1:0] norm_div(input logic [DIV_W-1:0] d);
        return (d == '0) ? DIV_W'(1) : d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_tick_scheduler_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick; search starts after ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] idx,
    output logic            found
);

    // Two passes: indices above ptr first, then wrap to 0..ptr.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int c = 0; c < NREQ; c++) begin
            if (!found && req[c] && (c > int'(ptr))) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                idx      = IDXW'(c);
            end
        end
        for (int c = 0; c < NREQ; c++) begin
            if (!found && req[c] && (c <= int'(ptr))) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                idx      = IDXW'(c);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/div_tick_scheduler.sv
// ============================================================================
// Module      : div_tick_scheduler
// Description : Clock-enable tick divider with round-robin capture of NREQ
//               requesters. Optional statistics via macro SCHED_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module div_tick_scheduler
    import sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDXW = 2
) (
    input  logic                 clk_a,
    input  logic                 rst_n,
    input  logic                 cfg_en,
    input  logic [DIV_W-1:0]     cfg_div,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*W-1:0]    req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 out_valid,
    output logic [W-1:0]         out_data,
    output logic [IDXW-1:0]      out_src,
    output logic                 tick,
    output logic                 busy,
    input  logic                 stat_clr,
    output logic [NREQ*16-1:0]   stat_cnt
);

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [IDXW-1:0]   rr_ptr_q, rr_ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [W-1:0]      out_data_q, out_data_d;
    logic [IDXW-1:0]   out_src_q, out_src_d;

    logic              tick_now;
    logic [NREQ-1:0]   arb_grant;
    logic [IDXW-1:0]   arb_idx;
    logic              xfer;
    logic [W-1:0]      req_word [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign req_word[i] = req_data[i*W +: W];
    end

    assign tick_now = (state_q == RUN) && (cnt_q == div_q - DIV_W'(1));

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_arb (
        .req   (req_valid & {NREQ{tick_now}}),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .found (xfer)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = xfer;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                div_d = norm_div(cfg_div);
                if (cfg_en) state_d = RUN;
            end
            RUN: begin
                // The period only picks up a new cfg_div at its boundary.
                if (tick_now) begin
                    cnt_d = '0;
                    div_d = norm_div(cfg_div);
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
                if (!cfg_en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (xfer) begin
            out_data_d = req_word[arb_idx];
            out_src_d  = arb_idx;
            rr_ptr_d   = arb_idx;
        end
    end

    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            div_q       <= DIV_W'(1);
            rr_ptr_q    <= IDXW'(NREQ - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign req_ready = arb_grant;
    assign tick      = tick_now;
    assign busy      = (state_q == RUN);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

`ifdef SCHED_STATS_EN
    logic [STAT_W-1:0] stat_q [NREQ];
    logic [STAT_W-1:0] stat_d [NREQ];

    // Clear has priority over a same-cycle grant.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            stat_d[i] = stat_q[i];
            if (stat_clr) begin
                stat_d[i] = '0;
            end else if (arb_grant[i] && (stat_q[i] != STAT_MAX)) begin
                stat_d[i] = stat_q[i] + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) stat_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) stat_q[i] <= stat_d[i];
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_stat_out
        assign stat_cnt[i*16 +: 16] = stat_q[i];
    end
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign stat_cnt        = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_div_tick_scheduler.sv
// ============================================================================
// Module      : tb_div_tick_scheduler
// Description : Directed bench with a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_div_tick_scheduler;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDXW = 2;

    logic                clk_a = 1'b0;
    logic                rst_n = 1'b0;
    logic                cfg_en = 1'b0;
    logic [7:0]          cfg_div = 8'd0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ*W-1:0]   req_data = {8'h40, 8'h30, 8'h20, 8'h10};
    logic                stat_clr = 1'b0;
    logic [NREQ-1:0]     req_ready;
    logic                out_valid;
    logic [W-1:0]        out_data;
    logic [IDXW-1:0]     out_src;
    logic                tick;
    logic                busy;
    logic [NREQ*16-1:0]  stat_cnt;

    div_tick_scheduler #(.NREQ(NREQ), .W(W), .IDXW(IDXW)) dut (
        .clk_a     (clk_a),
        .rst_n     (rst_n),
        .cfg_en    (cfg_en),
        .cfg_div   (cfg_div),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .tick      (tick),
        .busy      (busy),
        .stat_clr  (stat_clr),
        .stat_cnt  (stat_cnt)
    );

    always #5 clk_a = ~clk_a;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk_a) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: elapsed cycles in the current period, period length,
    // last winner, and the pending capture.
    bit  chk_on = 1'b0;
    bit  m_run;
    int  m_phase, m_period, m_last;
    bit  m_ov;
    int  m_od, m_os;
    int  m_stat [NREQ];
    bit  e_tick;
    int  e_g, e_rdy, cand;

    int  tick_log [$];
    int  ov_log   [$];
    int  src_log  [$];
    int  ov_cnt;
    int  bad_rdy;
    int  any_rdy;

    task automatic model_reset();
        m_run = 0; m_phase = 0; m_period = 1; m_last = NREQ - 1;
        m_ov = 0; m_od = 0; m_os = 0;
        for (int i = 0; i < NREQ; i++) m_stat[i] = 0;
    endtask

    always @(negedge clk_a) begin
        if (chk_on && rst_n) begin
            e_tick = m_run && (m_phase + 1 == m_period);
            e_g = -1;
            if (e_tick) begin
                for (int k = 1; k <= NREQ; k++) begin
                    cand = (m_last + k) % NREQ;
                    if (e_g < 0 && req_valid[cand]) e_g = cand;
                end
            end
            e_rdy = (e_g >= 0) ? (1 << e_g) : 0;
            chk("tick", tick, e_tick);
            chk("req_ready", req_ready, e_rdy);
            chk("busy", busy, m_run);
            chk("out_valid", out_valid, m_ov);
            chk("out_data", out_data, m_od);
            chk("out_src", out_src, m_os);
`ifdef SCHED_STATS_EN
            for (int i = 0; i < NREQ; i++) chk("stat_cnt", stat_cnt[i*16 +: 16], m_stat[i]);
`else
            chk("stat_cnt", stat_cnt, 0);
`endif
            if (tick) tick_log.push_back(cyc);
            if (out_valid) begin
                ov_log.push_back(cyc);
                src_log.push_back(int'(out_src));
                ov_cnt++;
            end
            if (req_ready[0] || req_ready[2]) bad_rdy++;
            if (req_ready != 0) any_rdy++;

            m_ov = (e_g >= 0);
            if (e_g >= 0) begin
                m_od = int'(req_data[e_g*W +: W]);
                m_os = e_g;
                m_last = e_g;
            end
`ifdef SCHED_STATS_EN
            if (stat_clr) begin
                for (int i = 0; i < NREQ; i++) m_stat[i] = 0;
            end else if (e_g >= 0 && m_stat[e_g] < 65535) begin
                m_stat[e_g]++;
            end
`endif
            if (!m_run || e_tick) m_period = (cfg_div == 0) ? 1 : int'(cfg_div);
            if (m_run && cfg_en && !e_tick) m_phase++;
            else m_phase = 0;
            m_run = cfg_en;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_a);
        #1;
    endtask

    task automatic wait_ov(input int n, input int bound);
        int b = 0;
        while (ov_cnt < n && b < bound) begin
            @(posedge clk_a);
            b++;
        end
        #1;
        if (ov_cnt < n) chk("wait_out_valid_timeout", ov_cnt, n);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_tick"}, tick, 0);
        chk({nm, "_req_ready"}, req_ready, 0);
        chk({nm, "_out_valid"}, out_valid, 0);
        chk({nm, "_out_data"}, out_data, 0);
        chk({nm, "_out_src"}, out_src, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_stat_cnt"}, stat_cnt, 0);
    endtask

    function automatic int qget(input int q [$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int c0;

    initial begin
        model_reset();
        step(2);
        chk_all_zero("reset");
        rst_n = 1'b1;
        chk_on = 1'b1;

        // 1: idle requesters, tick every 4th cycle
        cfg_div = 8'd4; cfg_en = 1'b1;
        tick_log.delete(); ov_cnt = 0; any_rdy = 0;
        step(17);
        chk("t1_tick_count", tick_log.size(), 4);
        chk("t1_out_valid_count", ov_cnt, 0);
        chk("t1_ready_count", any_rdy, 0);

        // 2: all requesters valid, div 2
        cfg_en = 1'b0; step(3);
        cfg_div = 8'd2; req_valid = 4'hF;
        tick_log.delete(); ov_log.delete(); src_log.delete(); ov_cnt = 0;
        cfg_en = 1'b1;
        wait_ov(5, 40);
        cfg_en = 1'b0; req_valid = 4'h0;
        chk("t2_src0", qget(src_log, 0), 0);
        chk("t2_src1", qget(src_log, 1), 1);
        chk("t2_src2", qget(src_log, 2), 2);
        chk("t2_src3", qget(src_log, 3), 3);
        chk("t2_src4", qget(src_log, 4), 0);
        chk("t2_latency", qget(ov_log, 0) - qget(tick_log, 0), 1);

        // 3: requesters 1 and 3, every cycle
        step(3);
        cfg_div = 8'd1; req_valid = 4'b1010;
        src_log.delete(); ov_cnt = 0; bad_rdy = 0;
        cfg_en = 1'b1;
        wait_ov(4, 20);
        cfg_en = 1'b0; req_valid = 4'h0;
        chk("t3_src0", qget(src_log, 0), 1);
        chk("t3_src1", qget(src_log, 1), 3);
        chk("t3_src2", qget(src_log, 2), 1);
        chk("t3_src3", qget(src_log, 3), 3);
        chk("t3_ready_0_or_2", bad_rdy, 0);

        // 4: period change 8 -> 3 mid-period, then 0
        step(3);
        cfg_div = 8'd8; tick_log.delete();
        cfg_en = 1'b1; c0 = cyc;
        step(3);
        cfg_div = 8'd3;
        step(16);
        chk("t4_first_period", qget(tick_log, 0) - c0, 8);
        chk("t4_second_period", qget(tick_log, 1) - qget(tick_log, 0), 3);
        chk("t4_third_period", qget(tick_log, 2) - qget(tick_log, 1), 3);
        cfg_div = 8'd0;
        step(4);
        tick_log.delete();
        step(5);
        chk("t4_div0_ticks", tick_log.size(), 5);

        // 5: drop enable in a tick cycle with requester 2 valid
        req_valid = 4'b0100;
        step(2);
        cfg_en = 1'b0;
        @(negedge clk_a);
        chk("t5_last_tick", tick, 1);
        chk("t5_last_ready", req_ready, 4'b0100);
        @(negedge clk_a);
        chk("t5_busy", busy, 0);
        chk("t5_out_valid", out_valid, 1);
        chk("t5_out_src", out_src, 2);
        chk("t5_out_data", out_data, 8'h30);
        tick_log.delete();
        step(6);
        chk("t5_no_ticks", tick_log.size(), 0);
        req_valid = 4'h0;

        // 5b: asynchronous reset mid-run
        cfg_div = 8'd2; req_valid = 4'hF; cfg_en = 1'b1;
        step(7);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk_all_zero("t5_midreset");
        @(posedge clk_a); #1;
        rst_n = 1'b1;
        step(5);
        cfg_en = 1'b0; req_valid = 4'h0;
        step(3);

`ifdef SCHED_STATS_EN
        // 6: statistics
        cfg_div = 8'd1; cfg_en = 1'b1;
        step(2);
        req_valid = 4'b0001; step(5); req_valid = 4'b0000;
        step(3);
        chk("t6_count5", stat_cnt[15:0], 16'd5);
        req_valid = 4'b0001; stat_clr = 1'b1;
        step(1);
        stat_clr = 1'b0; req_valid = 4'b0000;
        step(2);
        chk("t6_clear_wins", stat_cnt[15:0], 16'd0);
        req_valid = 4'b0001; step(65534); req_valid = 4'b0000;
        step(2);
        chk("t6_fffe", stat_cnt[15:0], 16'hFFFE);
        req_valid = 4'b0001; step(3); req_valid = 4'b0000;
        step(2);
        chk("t6_saturate", stat_cnt[15:0], 16'hFFFF);
        cfg_en = 1'b0;
        step(3);
`else
        // 6: statistics absent, clear is ignored
        cfg_div = 8'd1; cfg_en = 1'b1; req_valid = 4'b0001;
        stat_clr = 1'b1; step(3); stat_clr = 1'b0;
        step(3);
        chk("t6_stats_tied", stat_cnt, 0);
        cfg_en = 1'b0; req_valid = 4'b0000;
        step(3);
`endif

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
